// File: rtl/fir_fold_scheduler_pkg.sv
// Shared definitions for the folded FIR sequencer: state encoding and width helpers.
package fir_fold_scheduler_pkg;

  // One-hot state encoding; any other pattern is treated as illegal and recovers to S_CLEAR.
  typedef enum logic [4:0] {
    S_CLEAR = 5'b00001,
    S_IDLE  = 5'b00010,
    S_ISSUE = 5'b00100,
    S_DRAIN = 5'b01000,
    S_OUT   = 5'b10000
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

  // Address width for a table of the given depth, never narrower than one bit.
  function automatic int addr_width(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fir_fold_scheduler_tap_counter.sv
// Modulo-N up-counter used for the tap index and the history write pointer.
module fir_tap_counter
  import fir_fold_scheduler_pkg::*;
#(
  parameter int N  = 3,
  parameter int AW = addr_width(N)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          clr,
  input  logic          en,
  output logic [AW-1:0] cnt,
  output logic          last
);

  assign last = (cnt == AW'(N - 1));

  // Count up on enable and wrap after N-1, so the value never reaches N.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + AW'(1);
    end
  end

endmodule

// File: rtl/fir_fold_scheduler.sv
// Control sequencer for a folded single-MAC FIR: clears the sample history, accepts one
// sample at a time, issues all taps serially, waits for the MAC pipeline and hands off y.
module fir_fold_scheduler
  import fir_fold_scheduler_pkg::*;
#(
  parameter int TAPSIZE = 3,
  parameter int MUL_LAT = 1,
  parameter int ADD_LAT = 1,
  localparam int AW = addr_width(TAPSIZE)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          hist_wr,
  output logic          hist_zero,
  output logic [AW-1:0] hist_addr,
  output logic [AW-1:0] coef_addr,
  output logic          mul_en,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  localparam int DRAIN_LEN = MUL_LAT + ADD_LAT;
  localparam int DW        = addr_width(DRAIN_LEN + 1);

  state_t state;
  state_t state_next;

  logic [AW-1:0] k;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] newest;
  logic [AW-1:0] tap_addr;
  logic          k_last;
  logic          wr_last;
  logic          k_clr;
  logic          k_en;
  logic          transfer;
  logic [DW-1:0] drain_cnt;
  logic [MUL_LAT-1:0] en_pipe;
  logic [MUL_LAT-1:0] clr_pipe;

  logic          run;
  logic          in_ready_raw;
  logic          hist_wr_raw;
  logic          hist_zero_raw;
  logic [AW-1:0] hist_addr_raw;
  logic [AW-1:0] coef_addr_raw;
  logic          mul_en_raw;
  logic          out_valid_raw;

  fir_tap_counter #(.N(TAPSIZE), .AW(AW)) u_k_counter (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (k_clr),
    .en   (k_en),
    .cnt  (k),
    .last (k_last)
  );

  fir_tap_counter #(.N(TAPSIZE), .AW(AW)) u_wr_counter (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (1'b0),
    .en   (transfer),
    .cnt  (wr_ptr),
    .last (wr_last)
  );

  // Oldest taps sit behind the newest sample; wrap by adding TAPSIZE so any depth works.
  assign tap_addr = (newest >= k) ? (newest - k) : (newest + AW'(TAPSIZE) - k);

  // State register; reset always restarts with a full history clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_CLEAR;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and strobe decode for each phase of a sample's life.
  always_comb begin
    state_next    = state;
    in_ready_raw  = 1'b0;
    hist_wr_raw   = 1'b0;
    hist_zero_raw = 1'b0;
    hist_addr_raw = '0;
    coef_addr_raw = '0;
    mul_en_raw    = 1'b0;
    out_valid_raw = 1'b0;
    transfer      = 1'b0;
    k_clr         = 1'b0;
    k_en          = 1'b0;
    case (state)
      S_CLEAR: begin
        hist_wr_raw   = 1'b1;
        hist_zero_raw = 1'b1;
        hist_addr_raw = k;
        k_en          = 1'b1;
        if (k_last) state_next = S_IDLE;
      end
      S_IDLE: begin
        in_ready_raw  = 1'b1;
        hist_addr_raw = wr_ptr;
        if (in_valid) begin
          transfer    = 1'b1;
          hist_wr_raw = 1'b1;
          k_clr       = 1'b1;
          state_next  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mul_en_raw    = 1'b1;
        coef_addr_raw = k;
        hist_addr_raw = tap_addr;
        k_en          = 1'b1;
        if (k_last) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_cnt == '0) state_next = S_OUT;
      end
      S_OUT: begin
        out_valid_raw = 1'b1;
        if (out_ready) state_next = S_IDLE;
      end
      default: begin
        k_clr      = 1'b1;
        state_next = S_CLEAR;
      end
    endcase
  end

  // Remember which history slot holds the sample being filtered.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      newest <= '0;
    end else if (transfer) begin
      newest <= wr_ptr;
    end
  end

  // Hold in DRAIN long enough for the last product to pass the multiplier and adder.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      drain_cnt <= '0;
    end else if (state == S_ISSUE && k_last) begin
      drain_cnt <= DW'(DRAIN_LEN - 1);
    end else if (state == S_DRAIN && drain_cnt != '0) begin
      drain_cnt <= drain_cnt - DW'(1);
    end
  end

  // Delay the issue strobe and first-tap flag to line up with the multiplier output.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      en_pipe  <= '0;
      clr_pipe <= '0;
    end else begin
      en_pipe[0]  <= mul_en_raw;
      clr_pipe[0] <= mul_en_raw & (k == '0);
      for (int i = 1; i < MUL_LAT; i++) begin
        en_pipe[i]  <= en_pipe[i-1];
        clr_pipe[i] <= clr_pipe[i-1];
      end
    end
  end

  // Outputs are forced low while reset is held so an abort silences the datapath at once.
  assign run       = ~RST;
  assign in_ready  = in_ready_raw & run;
  assign hist_wr   = hist_wr_raw & run;
  assign hist_zero = hist_zero_raw & run;
  assign hist_addr = hist_addr_raw & {AW{run}};
  assign coef_addr = coef_addr_raw & {AW{run}};
  assign mul_en    = mul_en_raw & run;
  assign acc_en    = en_pipe[MUL_LAT-1] & run;
  assign acc_clr   = clr_pipe[MUL_LAT-1] & en_pipe[MUL_LAT-1] & run;
  assign out_valid = out_valid_raw & run;
  assign busy      = (state != S_IDLE) & run;

endmodule

// File: tb/tb_fir_fold_scheduler.sv
// Self-checking bench for fir_fold_scheduler: timeline model per sample, random gaps,
// random output stalls, back-to-back throughput, reset abort and a single-tap instance.
module tb_fir_fold_scheduler;

  localparam int T   = 3;
  localparam int M   = 1;
  localparam int A   = 1;
  localparam int LAT = T + M + A + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, hist_wr, hist_zero, mul_en, acc_clr, acc_en, out_valid, busy;
  logic [1:0] hist_addr, coef_addr;

  logic one_in_valid = 1'b0;
  logic one_out_ready = 1'b0;
  logic one_in_ready, one_hist_wr, one_hist_zero, one_mul_en, one_acc_clr, one_acc_en;
  logic one_out_valid, one_busy;
  logic [0:0] one_hist_addr, one_coef_addr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_wr_ptr = 0;
  int t0_cyc = 0;

  fir_fold_scheduler #(.TAPSIZE(T), .MUL_LAT(M), .ADD_LAT(A)) dut (
    .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready),
    .hist_wr(hist_wr), .hist_zero(hist_zero), .hist_addr(hist_addr),
    .coef_addr(coef_addr), .mul_en(mul_en), .acc_clr(acc_clr), .acc_en(acc_en),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  fir_fold_scheduler #(.TAPSIZE(1), .MUL_LAT(1), .ADD_LAT(1)) dut_one (
    .CLK(clk), .RST(rst), .in_valid(one_in_valid), .in_ready(one_in_ready),
    .hist_wr(one_hist_wr), .hist_zero(one_hist_zero), .hist_addr(one_hist_addr),
    .coef_addr(one_coef_addr), .mul_en(one_mul_en), .acc_clr(one_acc_clr),
    .acc_en(one_acc_en), .out_valid(one_out_valid), .out_ready(one_out_ready),
    .busy(one_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  // Drop reset and follow the history clear, ending in the first idle cycle.
  task automatic release_reset();
    rst = 1'b0;
    for (int c = 0; c < T; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({hist_wr, hist_zero, in_ready, busy, mul_en, out_valid} !== 6'b110100 ||
          hist_addr !== 2'(c)) begin
        errors++;
        $display("[TB] FAIL clear_cycle%0d got=%b addr=%0d want=110100 addr=%0d",
                 c, {hist_wr, hist_zero, in_ready, busy, mul_en, out_valid}, hist_addr, c);
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, hist_wr} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL clear_done got=%b want=100", {in_ready, busy, hist_wr});
    end
    tick();
    exp_wr_ptr = 0;
  endtask

  // One sample from acceptance to output handoff, checked cycle by cycle against the timeline.
  task automatic do_sample(input int gap, input int hold, input bit keep_valid);
    int w;
    int waited;
    int exp_addr;
    logic [7:0] exp_s;
    w = exp_wr_ptr;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({hist_wr, in_ready, busy, out_valid} !== 4'b0100) begin
        errors++;
        $display("[TB] FAIL idle_gap got=%b want=0100", {hist_wr, in_ready, busy, out_valid});
      end
      tick();
    end
    in_valid = 1'b1;
    out_ready = 1'($urandom_range(0, 1));
    #1;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 40) begin
      tick();
      #1;
      waited++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL accept_timeout got=%b want=1", in_ready);
    end
    t0_cyc = cyc;
    checks++;
    if ({hist_wr, hist_zero, mul_en, acc_clr, acc_en, out_valid, in_ready, busy} !== 8'b10000010 ||
        hist_addr !== 2'(w)) begin
      errors++;
      $display("[TB] FAIL transfer got=%b addr=%0d want=10000010 addr=%0d",
               {hist_wr, hist_zero, mul_en, acc_clr, acc_en, out_valid, in_ready, busy}, hist_addr, w);
    end
    for (int r = 1; r < 200; r++) begin
      tick();
      in_valid = keep_valid ? 1'b1 : 1'($urandom_range(0, 1));
      out_ready = (r < LAT) ? 1'($urandom_range(0, 1)) : (r - LAT >= hold);
      #1;
      exp_s = {1'b0, 1'b0, r <= T, r == 1 + M, (r >= 1 + M) && (r <= T + M), r >= LAT, 1'b0, 1'b1};
      checks++;
      if ({hist_wr, hist_zero, mul_en, acc_clr, acc_en, out_valid, in_ready, busy} !== exp_s) begin
        errors++;
        $display("[TB] FAIL strobes_r%0d got=%b want=%b", r,
                 {hist_wr, hist_zero, mul_en, acc_clr, acc_en, out_valid, in_ready, busy}, exp_s);
      end
      if (r <= T) begin
        exp_addr = (w - (r - 1) + T) % T;
        checks++;
        if (coef_addr !== 2'(r - 1) || hist_addr !== 2'(exp_addr)) begin
          errors++;
          $display("[TB] FAIL issue_addr_r%0d got coef=%0d hist=%0d want coef=%0d hist=%0d",
                   r, coef_addr, hist_addr, r - 1, exp_addr);
        end
      end
      if (r == LAT + hold) break;
    end
    tick();
    exp_wr_ptr = (w + 1) % T;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    #1;
    checks++;
    if ({in_ready, hist_wr, hist_zero, mul_en, acc_clr, acc_en, out_valid, busy,
         hist_addr, coef_addr} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_outputs got=%h want=000",
               {in_ready, hist_wr, hist_zero, mul_en, acc_clr, acc_en, out_valid, busy, hist_addr, coef_addr});
    end
    tick();
    release_reset();
  endtask

  task automatic test_single();
    do_sample(0, 0, 1'b0);
  endtask

  task automatic test_out_stall();
    do_sample(1, 5, 1'b0);
    do_sample(0, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    int prev;
    prev = -1;
    for (int i = 0; i < 4; i++) begin
      do_sample(0, 0, 1'b1);
      if (prev >= 0) begin
        checks++;
        if (t0_cyc - prev != T + M + A + 2) begin
          errors++;
          $display("[TB] FAIL period got=%0d want=%0d", t0_cyc - prev, T + M + A + 2);
        end
      end
      prev = t0_cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      do_sample($urandom_range(0, 3), $urandom_range(0, 4), 1'b0);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_abort();
    int waited;
    in_valid = 1'b1;
    #1;
    waited = 0;
    while (in_ready !== 1'b1 && waited < 40) begin
      tick();
      #1;
      waited++;
    end
    tick();
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (mul_en !== 1'b1 || coef_addr !== 2'd1) begin
      errors++;
      $display("[TB] FAIL abort_setup got mul=%b coef=%0d want mul=1 coef=1", mul_en, coef_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({in_ready, hist_wr, hist_zero, mul_en, acc_clr, acc_en, out_valid, busy,
         hist_addr, coef_addr} !== 12'h000) begin
      errors++;
      $display("[TB] FAIL abort_outputs got=%h want=000",
               {in_ready, hist_wr, hist_zero, mul_en, acc_clr, acc_en, out_valid, busy, hist_addr, coef_addr});
    end
    tick();
    tick();
    release_reset();
    do_sample(0, 0, 1'b0);
    in_valid = 1'b0;
  endtask

  task automatic test_tapsize_one();
    int prev;
    int waited;
    prev = -1;
    one_in_valid = 1'b1;
    one_out_ready = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      waited = 0;
      while (one_in_ready !== 1'b1 && waited < 20) begin
        tick();
        #1;
        waited++;
      end
      checks++;
      if (one_in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL one_accept got=%b want=1", one_in_ready);
      end
      if (prev >= 0) begin
        checks++;
        if (cyc - prev != 5) begin
          errors++;
          $display("[TB] FAIL one_period got=%0d want=5", cyc - prev);
        end
      end
      prev = cyc;
      for (int r = 0; r < 5; r++) begin
        checks++;
        if ({one_hist_wr, one_mul_en, one_acc_clr, one_acc_en, one_out_valid} !==
            {r == 0, r == 1, r == 2, r == 2, r == 4} ||
            one_hist_addr !== 1'b0 || one_coef_addr !== 1'b0) begin
          errors++;
          $display("[TB] FAIL one_r%0d got=%b addr=%b%b want=%b addr=00", r,
                   {one_hist_wr, one_mul_en, one_acc_clr, one_acc_en, one_out_valid},
                   one_hist_addr, one_coef_addr, {r == 0, r == 1, r == 2, r == 2, r == 4});
        end
        tick();
        #1;
      end
    end
    one_in_valid = 1'b0;
    tick();
  endtask

  initial begin
    $display("[TB] starting fir_fold_scheduler bench");
    test_reset();
    test_single();
    test_back_to_back();
    test_out_stall();
    test_random();
    test_abort();
    test_tapsize_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
